watch_set_controller: RTL
=========================

Name: watch_set_controller

Overview:
Sequences manual time-setting of the watch datapath. It turns debounced button inputs into single-cycle hour/min/sec increment pulses, with auto-repeat while a button is held. It also drives the field-select and blink information for the FND controller. It sits between btn_controller and watch; it is enabled only while watch mode is selected (sw_mode[1]=1).

Parameters:
BLINK_HALF, 50_000_000, cycles per blink half-period (0.5 s at 100 MHz)
REPEAT_DELAY, 50_000_000, cycles from the first increment to the first auto-repeat increment
REPEAT_PERIOD, 10_000_000, cycles between auto-repeat increments
TIMEOUT, 1_000_000_000, idle cycles in a SET state before automatic exit (10 s)

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
i_enable  input  1  watch mode selected; low forces IDLE
i_btn_set  input  1  one-cycle pulse: enter or exit set mode
i_btn_sel  input  1  one-cycle pulse: advance the field being set
i_btn_up  input  1  debounced level: increment the selected field while held
o_hour  output  1  one-cycle hour-increment pulse to watch
o_min  output  1  one-cycle min-increment pulse to watch
o_sec  output  1  one-cycle sec-increment pulse to watch
o_edit  output  1  high in any SET state
o_field  output  2  0=none, 1=hour, 2=min, 3=sec
o_blank  output  1  1 = blank the selected field digits this cycle

Behaviour:
- All outputs are registered. Reset takes effect on the clk edge where reset=1: state=IDLE, all counters=0, up_prev=1, armed=0, all outputs 0.
- States: IDLE, SET_HOUR, SET_MIN, SET_SEC. o_field = 0/1/2/3 respectively. o_edit = (state != IDLE).
- Transition priority per cycle, highest first:
  - i_enable=0: go to IDLE.
  - i_btn_set: IDLE->SET_HOUR; any SET state->IDLE.
  - Timeout in a SET state: go to IDLE.
  - i_btn_sel in a SET state: HOUR->MIN->SEC->HOUR. i_btn_sel in IDLE is ignored.
  - Up handling (below).
- Up handling:
  - up_prev registers i_btn_up every cycle, in every state.
  - A rising edge (i_btn_up=1, up_prev=0) in a SET state, in a cycle with no higher-priority event, sets armed=1 and rpt_cnt=0. The matching increment pulse is asserted on the next cycle.
  - While armed and i_btn_up=1, rpt_cnt increments each cycle. Further pulses occur REPEAT_DELAY cycles after the first pulse, then every REPEAT_PERIOD cycles.
  - i_btn_up=0, any state change, or i_enable=0 clears armed and rpt_cnt. Re-arming always requires a new rising edge, so a button already held on entry to set mode produces nothing.
  - Pulse routing: the pulse goes to o_hour, o_min or o_sec according to the current field. At most one of the three is high in any cycle, and none in IDLE.
  - No increment pulse is issued in a cycle in which a state transition is taken.
- Timeout:
  - to_cnt clears on entering a SET state, on i_btn_set, on i_btn_sel, and in any cycle with i_btn_up=1.
  - Otherwise it increments in SET states; on reaching TIMEOUT-1 the state goes to IDLE.
  - to_cnt holds 0 in IDLE.
- Blink:
  - In IDLE, o_blank=0 and blink_cnt=0.
  - In a SET state, blink_cnt counts 0..BLINK_HALF-1 and wraps; o_blank toggles on each wrap.
  - Entering a SET state, any field change, and every increment pulse reset blink_cnt=0 and o_blank=0, so the value is visible immediately after a change.
- Width rules: each counter is $clog2(param)+1 bits, with no overflow at the default values. Equality compares use param-1.
- Reset mid-operation (including mid-hold or mid-repeat) returns to IDLE with no pulse in the following cycle.

Test Plan:
Use BLINK_HALF=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, TIMEOUT=20 for all scenarios.
- Reset, then pulse set: o_edit=1, o_field=1, o_blank=0 for 4 cycles, then 1 for 4 cycles; sel x3 gives o_field 2,3,1.
- In SET_MIN, raise up at cycle T and hold 20 cycles: o_min pulses at T+1, T+9, T+12, T+15, T+18, T+21; o_hour and o_sec stay 0 throughout.
- Hold up, then pulse set: no pulse until up is released and re-pressed; after re-press, exactly one o_hour pulse.
- In SET_SEC, apply no input: IDLE after 20 cycles; a single up press at cycle 15 restarts the count, giving exit at cycle 35.
- i_btn_set and i_btn_sel in the same cycle while in SET_HOUR: go to IDLE. i_enable=0 during auto-repeat: IDLE next cycle, no further pulses.
- Assert reset during repeat: all outputs 0 the next cycle; up still held after reset releases produces no pulse.

Source files
------------

// File: rtl/watch_set_controller.sv
// watch_set_controller
// Turns debounced button inputs into single-cycle hour/min/sec increment pulses
// for the watch datapath, with auto-repeat while "up" is held, and drives the
// field-select / blink information for the FND controller.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   i_enable    watch mode selected; low forces IDLE
//   i_btn_set   one-cycle pulse: enter or leave set mode
//   i_btn_sel   one-cycle pulse: advance the field being set
//   i_btn_up    debounced level: increment the selected field while held
//   o_hour      one-cycle hour-increment pulse
//   o_min       one-cycle minute-increment pulse
//   o_sec       one-cycle second-increment pulse
//   o_edit      high in any SET state
//   o_field     0 = none, 1 = hour, 2 = min, 3 = sec
//   o_blank     1 = blank the selected field digits this cycle
module watch_set_controller #(
    parameter int unsigned BLINK_HALF    = 50_000_000,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter int unsigned TIMEOUT       = 1_000_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enable,
    input  logic       i_btn_set,
    input  logic       i_btn_sel,
    input  logic       i_btn_up,
    output logic       o_hour,
    output logic       o_min,
    output logic       o_sec,
    output logic       o_edit,
    output logic [1:0] o_field,
    output logic       o_blank
);

    // Encoding doubles as the o_field value.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHour = 2'd1,
        StMin  = 2'd2,
        StSec  = 2'd3
    } state_e;

    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned BlinkW = $clog2(BLINK_HALF) + 1;
    localparam int unsigned RptW   = $clog2(RptMax) + 1;
    localparam int unsigned ToW    = $clog2(TIMEOUT) + 1;

    localparam logic [BlinkW-1:0] BlinkLast     = BlinkW'(BLINK_HALF - 1);
    localparam logic [RptW-1:0]   RptDelayLast  = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0]   RptPeriodLast = RptW'(REPEAT_PERIOD - 1);
    localparam logic [ToW-1:0]    ToLast        = ToW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              up_prev_q, up_prev_d;
    logic              armed_q, armed_d;
    logic              rpt_phase_q, rpt_phase_d;  // 0: waiting first delay, 1: periodic
    logic [RptW-1:0]   rpt_cnt_q, rpt_cnt_d;
    logic [ToW-1:0]    to_cnt_q, to_cnt_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blank_q, blank_d;
    logic              edit_q, edit_d;
    logic              hour_q, hour_d;
    logic              min_q, min_d;
    logic              sec_q, sec_d;

    logic in_set;
    logic rise;
    logic timeout;
    logic trans;
    logic pulse;

    always_comb begin
        state_d     = state_q;
        up_prev_d   = i_btn_up;
        armed_d     = armed_q;
        rpt_phase_d = rpt_phase_q;
        rpt_cnt_d   = rpt_cnt_q;
        to_cnt_d    = to_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blank_d     = blank_q;
        pulse       = 1'b0;

        in_set  = (state_q != StIdle);
        rise    = i_btn_up & ~up_prev_q;
        timeout = in_set && (to_cnt_q == ToLast);

        // State transitions, highest priority first.
        if (!i_enable) begin
            state_d = StIdle;
        end else if (i_btn_set) begin
            state_d = in_set ? StIdle : StHour;
        end else if (timeout) begin
            state_d = StIdle;
        end else if (i_btn_sel && in_set) begin
            unique case (state_q)
                StHour:  state_d = StMin;
                StMin:   state_d = StSec;
                default: state_d = StHour;
            endcase
        end

        trans = !i_enable || (state_d != state_q);

        // Up handling: a transition cycle never produces a pulse and always disarms.
        if (trans || !i_btn_up) begin
            armed_d     = 1'b0;
            rpt_phase_d = 1'b0;
            rpt_cnt_d   = '0;
        end else if (rise && in_set) begin
            armed_d     = 1'b1;
            rpt_phase_d = 1'b0;
            rpt_cnt_d   = '0;
            pulse       = 1'b1;
        end else if (armed_q) begin
            if (rpt_cnt_q == (rpt_phase_q ? RptPeriodLast : RptDelayLast)) begin
                pulse       = 1'b1;
                rpt_phase_d = 1'b1;
                rpt_cnt_d   = '0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end

        // Inactivity timer: any user activity restarts it.
        if (state_d == StIdle || !in_set || i_btn_set || i_btn_sel || i_btn_up) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        // Blink restarts visible after entry, field change or increment.
        if (state_d == StIdle || state_d != state_q || pulse) begin
            blink_cnt_d = '0;
            blank_d     = 1'b0;
        end else if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d = '0;
            blank_d     = ~blank_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        edit_d = (state_d != StIdle);
        hour_d = pulse && (state_q == StHour);
        min_d  = pulse && (state_q == StMin);
        sec_d  = pulse && (state_q == StSec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            up_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
            rpt_phase_q <= 1'b0;
            rpt_cnt_q   <= '0;
            to_cnt_q    <= '0;
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
            edit_q      <= 1'b0;
            hour_q      <= 1'b0;
            min_q       <= 1'b0;
            sec_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            up_prev_q   <= up_prev_d;
            armed_q     <= armed_d;
            rpt_phase_q <= rpt_phase_d;
            rpt_cnt_q   <= rpt_cnt_d;
            to_cnt_q    <= to_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
            edit_q      <= edit_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
        end
    end

    assign o_field = state_q;
    assign o_edit  = edit_q;
    assign o_blank = blank_q;
    assign o_hour  = hour_q;
    assign o_min   = min_q;
    assign o_sec   = sec_q;

endmodule
